// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide HCI request into MP word-wide TCDM requests and merges the
// narrow responses back into one wide response; narrow grants may arrive in any order.
module redmule_tcdm_splitter #(
    parameter int unsigned MP = 4,
    parameter int unsigned IW = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       add_i,
    input  logic              wen_i,
    input  logic [MP*4-1:0]   be_i,
    input  logic [MP*32-1:0]  data_i,
    input  logic [IW-1:0]     id_i,
    output logic              r_valid_o,
    output logic [MP*32-1:0]  r_data_o,
    output logic [IW-1:0]     r_id_o,
    output logic              busy_o,
    output logic [MP-1:0]     tcdm_req_o,
    input  logic [MP-1:0]     tcdm_gnt_i,
    output logic [MP*32-1:0]  tcdm_add_o,
    output logic [MP-1:0]     tcdm_wen_o,
    output logic [MP*4-1:0]   tcdm_be_o,
    output logic [MP*32-1:0]  tcdm_data_o,
    input  logic [MP-1:0]     tcdm_r_valid_i,
    input  logic [MP*32-1:0]  tcdm_r_data_i
);
    localparam int unsigned DW = MP * 32;

    typedef enum logic {ISSUE, COLLECT} state_e;

    state_e          state_q, state_d;
    logic [MP-1:0]   granted_q, granted_d;
    logic [MP-1:0]   pending_q, pending_d;
    logic [IW-1:0]   id_q, id_d;
    logic [DW-1:0]   rbuf_q, rbuf_d;
    logic            r_valid_q, r_valid_d;
    logic [DW-1:0]   r_data_q, r_data_d;
    logic [IW-1:0]   r_id_q, r_id_d;

    logic [MP-1:0]   new_gnt;
    logic            all_g;
    logic            complete;

    for (genvar i = 0; i < MP; i++) begin : g_port
        assign tcdm_add_o[32*i +: 32] = add_i + 32'(4 * i);
    end
    assign tcdm_wen_o  = {MP{wen_i}};
    assign tcdm_be_o   = be_i;
    assign tcdm_data_o = data_i;

    // Ports already granted drop their request so each word is issued once.
    assign tcdm_req_o = {MP{req_i && (state_q == ISSUE)}} & ~granted_q;
    assign new_gnt    = tcdm_req_o & tcdm_gnt_i;
    assign all_g      = &(granted_q | new_gnt);
    assign gnt_o      = req_i && (state_q == ISSUE) && all_g;
    assign complete   = (state_q == COLLECT) && ((pending_q & ~tcdm_r_valid_i) == '0);

    assign busy_o    = (state_q == COLLECT) || (|granted_q);
    assign r_valid_o = r_valid_q;
    assign r_data_o  = r_data_q;
    assign r_id_o    = r_id_q;

    always_comb begin
        state_d   = state_q;
        granted_d = granted_q | new_gnt;
        pending_d = (pending_q & ~tcdm_r_valid_i) | new_gnt;
        id_d      = id_q;
        rbuf_d    = rbuf_q;
        r_valid_d = 1'b0;
        r_data_d  = r_data_q;
        r_id_d    = r_id_q;
        // Responses without a matching pending bit are stale and dropped.
        for (int unsigned i = 0; i < MP; i++) begin
            if (pending_q[i] && tcdm_r_valid_i[i]) begin
                rbuf_d[32*i +: 32] = tcdm_r_data_i[32*i +: 32];
            end
        end
        if (gnt_o) begin
            granted_d = '0;
            id_d      = id_i;
            state_d   = COLLECT;
        end
        if (complete) begin
            r_valid_d = 1'b1;
            r_data_d  = rbuf_d;
            r_id_d    = id_q;
            state_d   = ISSUE;
        end
        if (clear_i) begin
            granted_d = '0;
            pending_d = '0;
            state_d   = ISSUE;
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ISSUE;
            granted_q <= '0;
            pending_q <= '0;
            id_q      <= '0;
            rbuf_q    <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            granted_q <= granted_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            rbuf_q    <= rbuf_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_id_q    <= r_id_d;
        end
    end
endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Random and directed stimulus for redmule_tcdm_splitter against a word-memory
// reference model, with a response scoreboard and a narrow-side responder.
module tb_redmule_tcdm_splitter;
    localparam int MP = 4;
    localparam int IW = 8;
    localparam int DW = MP * 32;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              req_i = 1'b0;
    logic              gnt_o;
    logic [31:0]       add_i = '0;
    logic              wen_i = 1'b1;
    logic [MP*4-1:0]   be_i = '0;
    logic [DW-1:0]     data_i = '0;
    logic [IW-1:0]     id_i = '0;
    logic              r_valid_o;
    logic [DW-1:0]     r_data_o;
    logic [IW-1:0]     r_id_o;
    logic              busy_o;
    logic [MP-1:0]     tcdm_req_o;
    logic [MP-1:0]     tcdm_gnt_i = '0;
    logic [DW-1:0]     tcdm_add_o;
    logic [MP-1:0]     tcdm_wen_o;
    logic [MP*4-1:0]   tcdm_be_o;
    logic [DW-1:0]     tcdm_data_o;
    logic [MP-1:0]     tcdm_r_valid_i = '0;
    logic [DW-1:0]     tcdm_r_data_i = '0;

    always #5 clk_i = ~clk_i;

    redmule_tcdm_splitter #(.MP(MP), .IW(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .data_i(data_i), .id_i(id_i),
        .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_id_o(r_id_o), .busy_o(busy_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i)
    );

    typedef struct { logic rd; logic [DW-1:0] data; logic [IW-1:0] id; } exp_t;
    typedef struct { int due; logic [31:0] d; } rsp_t;

    exp_t          exp_q[$];
    int            gcyc_q[$];
    int            rcyc_q[$];
    rsp_t          rq[MP][$];
    logic [31:0]   tmem [logic [29:0]];   // responder storage
    logic [31:0]   rmem [logic [29:0]];   // reference storage
    int            lat_fix[MP];           // 0 selects a random latency
    int            gmode = 0;             // 0 grant all, 1 random, 2 force_gnt
    logic [MP-1:0] force_gnt = '0;
    logic [MP-1:0] gdone = '0;
    bit            gnt_hit = 0;
    bit            coll = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_9600;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Narrow-side memory: grants, field checks, delayed responses.
    always @(negedge clk_i) begin
        logic [MP-1:0] g;
        logic [MP-1:0] v;
        logic [DW-1:0] rd;
        logic [31:0]   a;
        logic [31:0]   w;
        logic          exp_g;
        int            lat;
        g = '0;
        v = '0;
        for (int i = 0; i < MP; i++) rd[32*i +: 32] = $urandom;
        if (!rst_ni) begin
            tcdm_gnt_i     = '0;
            tcdm_r_valid_i = '0;
        end else begin
            for (int i = 0; i < MP; i++) begin
                if (rq[i].size() > 0 && rq[i][0].due <= cyc) begin
                    v[i] = 1'b1;
                    rd[32*i +: 32] = rq[i][0].d;
                    void'(rq[i].pop_front());
                end
                if (gdone[i]) check("rereq_after_grant", DW'(tcdm_req_o[i]), DW'(0));
                if (tcdm_req_o[i]) begin
                    case (gmode)
                        0:       g[i] = 1'b1;
                        1:       g[i] = ($urandom_range(0, 1) == 1);
                        default: g[i] = force_gnt[i];
                    endcase
                end
                if (g[i]) begin
                    a = add_i + 32'(4 * i);
                    check("port_add", DW'(tcdm_add_o[32*i +: 32]), DW'(a));
                    check("port_wen", DW'(tcdm_wen_o[i]), DW'(wen_i));
                    check("port_be", DW'(tcdm_be_o[4*i +: 4]), DW'(be_i[4*i +: 4]));
                    check("port_wdata", DW'(tcdm_data_o[32*i +: 32]), DW'(data_i[32*i +: 32]));
                    a = tcdm_add_o[32*i +: 32];
                    w = tmem.exists(a[31:2]) ? tmem[a[31:2]] : dflt(a);
                    if (!tcdm_wen_o[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (tcdm_be_o[4*i+b]) w[8*b +: 8] = tcdm_data_o[32*i+8*b +: 8];
                        tmem[a[31:2]] = w;
                        w = $urandom;
                    end
                    lat = (lat_fix[i] != 0) ? lat_fix[i] : int'($urandom_range(1, 3));
                    rq[i].push_back('{cyc + lat, w});
                end
            end
            tcdm_gnt_i     = g;
            tcdm_r_valid_i = v;
            tcdm_r_data_i  = rd;
            #1;
            exp_g = req_i && (&(gdone | g));
            check("gnt_o", DW'(gnt_o), DW'(exp_g));
            if (gnt_o) gnt_hit = 1;
            if (clear_i || exp_g) gdone = '0;
            else gdone = gdone | g;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_i) begin
        exp_t e;
        #2;
        if (rst_ni) begin
            if (r_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rvalid: r_valid_o=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("r_id", DW'(r_id_o), DW'(e.id));
                    if (e.rd) check("r_data", r_data_o, e.data);
                end
                rcyc_q.push_back(cyc);
                coll = 0;
            end
            if (coll) begin
                check("collect_no_req", DW'(tcdm_req_o), DW'(0));
                check("collect_busy", DW'(busy_o), DW'(1));
            end
            if (clear_i) coll = 0;
            if (gnt_o) begin
                coll = 1;
                gcyc_q.push_back(cyc);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [MP*4-1:0] be,
                         input logic [DW-1:0] d, input logic [IW-1:0] id, input bit push);
        int   n;
        exp_t e;
        logic [31:0] ai;
        logic [31:0] word;
        add_i = a; wen_i = w; be_i = be; data_i = d; id_i = id;
        req_i = 1'b1;
        gnt_hit = 0;
        n = 0;
        while (!gnt_hit && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!gnt_hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout: no gnt_o within %0d cycles for id %0h, expected a grant", n, id);
        end else if (push) begin
            e.rd = w; e.id = id; e.data = '0;
            for (int i = 0; i < MP; i++) begin
                ai = a + 32'(4 * i);
                word = rmem.exists(ai[31:2]) ? rmem[ai[31:2]] : dflt(ai);
                if (w) e.data[32*i +: 32] = word;
                else begin
                    for (int b = 0; b < 4; b++)
                        if (be[4*i+b]) word[8*b +: 8] = d[32*i+8*b +: 8];
                    rmem[ai[31:2]] = word;
                end
            end
            exp_q.push_back(e);
        end
        gnt_hit = 0;
        req_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic timing(input string name, input int t0, input int n, input int goff, input int roff);
        for (int k = 0; k < n; k++) begin
            chk_i({name, "_gnt_cycle"}, (k < gcyc_q.size()) ? gcyc_q[k] - t0 : -1, goff + 2*k);
            chk_i({name, "_rvalid_cycle"}, (k < rcyc_q.size()) ? rcyc_q[k] - t0 : -1, roff + 2*k);
        end
        gcyc_q.delete();
        rcyc_q.delete();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int t0;
        for (int i = 0; i < MP; i++) lat_fix[i] = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #2;
        check("rst_gnt", DW'(gnt_o), DW'(0));
        check("rst_tcdm_req", DW'(tcdm_req_o), DW'(0));
        check("rst_rvalid", DW'(r_valid_o), DW'(0));
        check("rst_rdata", r_data_o, DW'(0));
        check("rst_rid", DW'(r_id_o), DW'(0));
        check("rst_busy", DW'(busy_o), DW'(0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        gcyc_q.delete();
        rcyc_q.delete();

        // Simple read, immediate grants
        t0 = cyc;
        issue(32'h100, 1'b1, '1, rnd_data(), 8'h5A, 1);
        drain();
        timing("simple", t0, 1, 0, 2);

        // Staggered grants: port 0, then 2, then 1 and 3
        gmode = 2;
        t0 = cyc;
        fork
            issue(32'h200, 1'b1, '1, rnd_data(), 8'h21, 1);
            begin
                force_gnt = 4'b0001; @(posedge clk_i); #1;
                force_gnt = 4'b0100; @(posedge clk_i); #1;
                force_gnt = 4'b0000; @(posedge clk_i); #1;
                force_gnt = 4'b1010; @(posedge clk_i); #1;
                force_gnt = 4'b0000;
            end
        join
        gmode = 0;
        drain();
        timing("stagger", t0, 1, 3, 5);

        // Partial write then read back
        issue(32'h100, 1'b0, 16'hF0F0, rnd_data(), 8'h33, 1);
        issue(32'h100, 1'b1, '1, rnd_data(), 8'h34, 1);
        drain();
        gcyc_q.delete();
        rcyc_q.delete();

        // Back-to-back reads
        t0 = cyc;
        for (int k = 0; k < 4; k++) issue(32'h140 + 32'(16*k), 1'b1, '1, rnd_data(), IW'(k + 1), 1);
        drain();
        timing("b2b", t0, 4, 0, 2);

        // Address wrap: write then read across 0xFFFFFFFC -> 0x0
        issue(32'hFFFF_FFF8, 1'b0, '1, rnd_data(), 8'h77, 1);
        issue(32'hFFFF_FFF8, 1'b1, '1, rnd_data(), 8'h78, 1);
        issue(32'h0000_0000, 1'b1, '1, rnd_data(), 8'h79, 1);
        drain();

        // Clear while ports 1 and 3 are still outstanding
        lat_fix[1] = 5;
        lat_fix[3] = 5;
        issue(32'h300, 1'b1, '1, rnd_data(), 8'hC0, 0);
        @(posedge clk_i); #1;
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        @(negedge clk_i); #2;
        check("clear_busy", DW'(busy_o), DW'(0));
        check("clear_rvalid", DW'(r_valid_o), DW'(0));
        repeat (6) @(posedge clk_i);
        #1;
        lat_fix[1] = 1;
        lat_fix[3] = 1;
        issue(32'h300, 1'b1, '1, rnd_data(), 8'hC1, 1);
        drain();

        // Random traffic: random grants, latencies, addresses (with wrap) and gaps
        gmode = 1;
        for (int i = 0; i < MP; i++) lat_fix[i] = 0;
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            a = (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFE0 : 32'h0) + 32'(4 * $urandom_range(0, 11));
            issue(a, 1'($urandom_range(0, 1)), 16'($urandom), rnd_data(), IW'($urandom), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/redmule_tcdm_splitter.md
# redmule_tcdm_splitter

Memory-side stage placed directly below the RedMulE streamer. It takes one wide HCI request of `MP*32` bits and splits it into `MP` independent 32-bit TCDM requests at consecutive word addresses. It accepts each narrow grant independently and reassembles the narrow read responses into a single wide response. Unlike a plain AND-of-grants binding, it tolerates ports that are granted in different cycles.

## Interface
Parameters:
- `MP`, 4: number of narrow 32-bit TCDM ports.
- `DW`, MP*32: wide data width; fixed, not overridable.
- `IW`, 8: transaction ID width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous soft clear.
- `req_i`, in, 1: wide request.
- `gnt_o`, out, 1: wide grant.
- `add_i`, in, 32: wide byte address; word-aligned.
- `wen_i`, in, 1: 1 = read, 0 = write.
- `be_i`, in, DW/8: byte enables.
- `data_i`, in, DW: write data.
- `id_i`, in, IW: transaction ID.
- `r_valid_o`, out, 1: wide response valid; one-cycle pulse.
- `r_data_o`, out, DW: wide read data.
- `r_id_o`, out, IW: ID of the returned transaction.
- `busy_o`, out, 1: transaction in flight.
- `tcdm_req_o`, out, MP: narrow requests.
- `tcdm_gnt_i`, in, MP: narrow grants.
- `tcdm_add_o`, out, MP×32: narrow addresses.
- `tcdm_wen_o`, out, MP: narrow read/write flags.
- `tcdm_be_o`, out, MP×4: narrow byte enables.
- `tcdm_data_o`, out, MP×32: narrow write data.
- `tcdm_r_valid_i`, in, MP: narrow response valids.
- `tcdm_r_data_i`, in, MP×32: narrow read data.

## Operation
- FSM states: ISSUE (reset state) and COLLECT.
- Registers:
  - `granted_q[MP]`: ports already granted in the current issue.
  - `pending_q[MP]`: ports granted whose response has not yet arrived.
  - `id_q`: ID of the transaction being collected.
  - Response data buffer `rbuf_q[MP][32]`.
  - Output registers for `r_valid_o`, `r_data_o` and `r_id_o`.
- Narrow field mapping for port i:
  - address = `add_i + 4*i`, modulo 2^32; wrap is allowed.
  - be = `be_i[4i+:4]`.
  - data = `data_i[32i+:32]`.
  - wen = `wen_i`.
- `tcdm_req_o[i]` = `req_i` & (state==ISSUE) & ~`granted_q[i]`.
- Define `all_g` = &(`granted_q` | (`tcdm_req_o` & `tcdm_gnt_i`)).
- `gnt_o` = `req_i` & (state==ISSUE) & `all_g`; combinational.
- On `gnt_o`:
  - Clear `granted_q`.
  - Capture `id_i` into `id_q`.
  - Go to COLLECT.
- Without `gnt_o`:
  - `granted_q` |= `tcdm_req_o` & `tcdm_gnt_i`.
  - The wide master must hold `req_i` and all fields stable until `gnt_o` (HCI rule).
- `pending_q` update each cycle:
  - Set bit i on a narrow grant of port i.
  - Clear bit i on `tcdm_r_valid_i[i]`; also store `tcdm_r_data_i[i]` into `rbuf_q[i]`.
  - `tcdm_r_valid_i[i]` with `pending_q[i]`=0 is ignored.
- Completion is `state==COLLECT` & (`pending_q` & ~`tcdm_r_valid_i`)==0. On completion:
  - Next cycle `r_valid_o`=1.
  - `r_data_o` = merged data: this cycle's incoming words override `rbuf_q`.
  - `r_id_o` = `id_q`.
  - State returns to ISSUE.
- Writes complete the same way. TCDM returns `r_valid` for writes; the data content is don't-care.
- `busy_o` = (state==COLLECT) | (|`granted_q`).
- `clear_i` takes priority over all other updates. It:
  - clears `granted_q` and `pending_q`;
  - sets state to ISSUE;
  - sets `r_valid_o` to 0 next cycle;
  - causes any late narrow responses to be dropped (pending bit already 0).

## Timing
- Reset values: state ISSUE, all masks 0, `r_valid_o`=0, `r_data_o`=0, `r_id_o`=0.
- Combinational outputs during reset: `gnt_o`=0 and `tcdm_req_o`=0 whenever `req_i`=0.
- Reset asserted mid-transaction abandons it. The upstream must not rely on a response after reset.
- Best case: all ports granted at cycle t → `gnt_o` at t. Narrow `r_valid` at t+1. `r_valid_o` at t+2.
- The next request issues at t+2, the same cycle as `r_valid_o`. Sustained throughput is one wide transaction per 2 cycles.
- Staggered grants: `gnt_o` coincides with the last missing narrow grant. Responses from earlier-granted ports are captured while still in ISSUE.
- A narrow `r_valid` arriving in the same cycle as a narrow grant on another port is handled independently.
- No narrow requests are raised in COLLECT.
- A wide `req_i` in COLLECT sees `gnt_o`=0.
- Exactly one wide transaction is outstanding at any time.

## Test plan
- **Simple read.** MP=4, `add_i`=0x100, all grants immediate, `id_i`=0x5A.
  - Narrow addresses 0x100/104/108/10C.
  - `gnt_o` at t, `r_valid_o` at t+2.
  - `r_data_o` = {w3,w2,w1,w0}, `r_id_o`=0x5A.
- **Staggered grants.** Port 0 granted at t, port 2 at t+1, ports 1 and 3 at t+3.
  - Port 0 is not re-requested after t.
  - `gnt_o` only at t+3; `r_valid_o` at t+5 with the correct data.
- **Write.** `be_i`=0xF0F0, `wen_i`=0.
  - Per-port be = 0x0, 0xF, 0x0, 0xF.
  - Correct data slices on each port.
  - `r_valid_o` pulses once.
- **Back-to-back.** 4 requests with immediate grants and responses.
  - `gnt_o` at t, t+2, t+4, t+6.
  - 4 `r_valid_o` pulses, IDs in order.
- **Address wrap.** `add_i`=0xFFFFFFF8 → port addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- **Clear mid-collect.** `clear_i` while responses from ports 1 and 3 are outstanding.
  - Their later `r_valid` is ignored; no `r_valid_o`.
  - `busy_o`=0 the next cycle.
  - A subsequent request completes normally.
